imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter MAX_WORDS, default 128, giving the instruction-memory capacity in 32-bit words (512 bytes).
REQ-002 The block SHALL have parameter ADDR_W, default 9, giving the byte-address width of the instruction memory.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: a one-cycle pulse that begins a program load.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the byte-stream source has a byte.
REQ-007 The block SHALL have port in_data, input, 8 bits: the stream byte.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the loader accepts a byte this cycle.
REQ-009 The block SHALL have port mem_we, output, 1 bit: instruction-memory word write strobe.
REQ-010 The block SHALL have port mem_addr, output, ADDR_W bits: word-aligned byte address of the write.
REQ-011 The block SHALL have port mem_wdata, output, 32 bits: big-endian instruction word.
REQ-012 The block SHALL have ports busy, done, error and cpu_hold, each output, 1 bit: load in progress / load ok / load failed / pipeline held in reset.

Function
REQ-013 A byte SHALL transfer on a rising edge where in_valid=1 and in_ready=1; in_ready SHALL depend on state only, never on in_valid.
REQ-014 The FSM SHALL have the states IDLE, HDR, DATA, WRITE, CHECK, DONE and ERR.
REQ-015 IDLE: in_ready=0; start moves to HDR and clears the word index, byte count and checksum.
REQ-016 HDR: in_ready=1; the accepted byte is the word count N, and checksum = N; N=0 or N>MAX_WORDS goes to ERR, otherwise the FSM goes to DATA.
REQ-017 DATA: in_ready=1; each accepted byte shifts into the assembly register, first byte to [31:24]; checksum ^= byte; after the 4th byte the FSM goes to WRITE.
REQ-018 WRITE: in_ready=0; mem_we=1 for exactly one cycle with mem_addr = index*4 (ADDR_W bits) and mem_wdata = assembled word; index increments; index==N goes to CHECK, otherwise DATA.
REQ-019 CHECK: in_ready=1; an accepted byte equal to the checksum goes to DONE, otherwise ERR.
REQ-020 DONE: done=1, cpu_hold=0, busy=0; start begins a reload, going to HDR with cpu_hold=1 from the next cycle.
REQ-021 ERR: error=1, cpu_hold=1, busy=0; start retries by going to HDR.
REQ-022 busy SHALL be 1 exactly in HDR, DATA, WRITE and CHECK; cpu_hold SHALL be 0 only in DONE.
REQ-023 start SHALL be ignored while busy=1.
REQ-024 Idle source cycles (in_valid=0) SHALL stall the FSM without changing any state.
REQ-025 Minimum load latency SHALL be 5N+2 cycles from header acceptance to done=1; done rises on the cycle after the checksum byte is accepted.
REQ-026 mem_we SHALL be 0 in every state except WRITE; mem_addr and mem_wdata are don't-care when mem_we=0 but SHALL hold their last value.

Reset
REQ-027 reset=0 SHALL asynchronously force state IDLE and set in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0 and cpu_hold=1, and clear index, byte count and checksum.
REQ-028 A reset in mid-load SHALL abandon the load; words already written SHALL NOT be rolled back.

Structure
REQ-029 The state enum, MAX_WORDS and the 4-bytes-per-word constant SHALL live in the shared pipeline package.
REQ-030 One sub-module, word_assembler (byte shift register plus 2-bit byte counter and full flag), SHALL be instantiated; everything else SHALL be in imem_loader.

Verification
REQ-031 Nominal load: start, then bytes 01 12 34 56 78 09 -> a single write, addr 0x000 data 0x12345678; done=1, cpu_hold=0.
REQ-032 Zero count: header 00 -> error=1, no mem_we, cpu_hold=1; a subsequent start and a valid stream -> done=1.
REQ-033 Bad checksum: bytes 01 12 34 56 78 0A -> the write occurs, then error=1 and cpu_hold stays 1.
REQ-034 Stream gaps: REQ-031 stream with in_valid low on alternating cycles -> identical writes and done; no byte is dropped or duplicated.
REQ-035 Full fill: N=128 with a correct checksum -> 128 writes, last addr 0x1FC; then a start pulse reloads and cpu_hold=1 until the second done.
REQ-036 Mid-load reset: reset asserted after the 2nd data byte -> all outputs take their reset values immediately; a fresh load then succeeds.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// ---------------------------------------------------------------------------
// imem_loader_pkg
// Shared definitions for the instruction-memory loader: default memory
// capacity, bytes per instruction word and the loader FSM state encoding.
// ---------------------------------------------------------------------------
package imem_loader_pkg;

    // Default instruction-memory capacity in 32-bit words (512 bytes).
    localparam int IMEM_MAX_WORDS = 128;

    // Instruction words arrive as four bytes, most significant first.
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        DATA  = 3'd2,
        WRITE = 3'd3,
        CHECK = 3'd4,
        DONE  = 3'd5,
        ERR   = 3'd6
    } state_t;

    // True while a load is in flight (header through checksum).
    function automatic logic state_is_busy(input state_t s);
        return (s == HDR) || (s == DATA) || (s == WRITE) || (s == CHECK);
    endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// ---------------------------------------------------------------------------
// word_assembler
// Collects stream bytes into a big-endian 32-bit word.
//   clk       : clock
//   reset     : asynchronous active-low reset
//   clear     : restart assembly at byte 0 (start of a new load)
//   shift_en  : byte_in is consumed this cycle
//   byte_in   : incoming stream byte
//   word_next : the word as it will look once byte_in is shifted in
//   last_byte : the byte being offered now completes a word
//   full      : a complete word has been assembled and not yet overwritten
// ---------------------------------------------------------------------------
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_next,
    output logic        last_byte,
    output logic        full
);

    // Only the three older bytes need storing; the newest comes from byte_in.
    logic [23:0] word_reg;
    logic [1:0]  cnt_reg;
    logic        full_reg;

    genvar gi;
    generate
        for (gi = 0; gi < BYTES_PER_WORD; gi = gi + 1) begin : g_lane
            if (gi == 0) begin : g_newest
                assign word_next[7:0] = byte_in;
            end else begin : g_older
                assign word_next[8*gi +: 8] = word_reg[8*(gi-1) +: 8];
            end
        end
    endgenerate

    assign last_byte = (cnt_reg == 2'(BYTES_PER_WORD - 1));
    assign full      = full_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_reg <= '0;
            cnt_reg  <= '0;
            full_reg <= 1'b0;
        end else if (clear) begin
            word_reg <= '0;
            cnt_reg  <= '0;
            full_reg <= 1'b0;
        end else if (shift_en) begin
            word_reg <= word_next[23:0];
            cnt_reg  <= cnt_reg + 2'd1;
            // Counter wraps naturally; full marks the word just completed.
            full_reg <= last_byte;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
// Loads a program from a byte stream into instruction memory while holding
// the CPU pipeline in reset. Stream format: word count N, then 4*N bytes
// (big-endian words), then an XOR checksum over the count and data bytes.
//   clk        : clock (rising edge)
//   reset      : asynchronous active-low reset
//   start      : one-cycle pulse that begins a load (ignored while busy)
//   in_valid   : source offers in_data
//   in_data    : stream byte
//   in_ready   : loader takes a byte this cycle (state-only)
//   mem_we     : one-cycle word write strobe
//   mem_addr   : word-aligned byte address of the write
//   mem_wdata  : big-endian instruction word
//   busy       : load in progress
//   done       : last load succeeded
//   error      : last load failed (bad count or checksum)
//   cpu_hold   : pipeline held in reset (low only after a good load)
// ---------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int MAX_WORDS = IMEM_MAX_WORDS,
    parameter int ADDR_W    = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              cpu_hold
);

    state_t            state_reg;
    state_t            state_next;

    logic [7:0]        count_reg;
    logic [7:0]        index_reg;
    logic [7:0]        csum_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [31:0]       mem_wdata_reg;

    logic              accept;
    logic              start_load;
    logic              header_bad;
    logic [7:0]        index_inc;

    logic [31:0]       asm_word_next;
    logic              asm_last;
    logic              asm_full;

    assign accept     = in_valid && in_ready;
    assign start_load = start && !busy;
    assign index_inc  = index_reg + 8'd1;
    assign header_bad = (in_data == 8'd0) || (32'(in_data) > 32'(MAX_WORDS));

    word_assembler u_word_assembler (
        .clk       (clk),
        .reset     (reset),
        .clear     (start_load),
        .shift_en  (accept && (state_reg == DATA)),
        .byte_in   (in_data),
        .word_next (asm_word_next),
        .last_byte (asm_last),
        .full      (asm_full)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_next = HDR;
                end
            end
            HDR: begin
                if (accept) begin
                    state_next = header_bad ? ERR : DATA;
                end
            end
            DATA: begin
                if (accept && asm_last) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                state_next = (index_inc == count_reg) ? CHECK : DATA;
            end
            CHECK: begin
                if (accept) begin
                    state_next = (in_data == csum_reg) ? DONE : ERR;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Status outputs decode straight from the state so reset takes them
    // to their idle values without waiting for a clock.
    always_comb begin
        in_ready = (state_reg == HDR) || (state_reg == DATA) || (state_reg == CHECK);
        busy     = state_is_busy(state_reg);
        done     = (state_reg == DONE);
        error    = (state_reg == ERR);
        cpu_hold = (state_reg != DONE);
        mem_we   = (state_reg == WRITE) && asm_full;
    end

    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;

    // Datapath: count, index, checksum and the write address/data, which are
    // captured as the word completes so they hold steady after the strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg     <= '0;
            index_reg     <= '0;
            csum_reg      <= '0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
        end else if (start_load) begin
            count_reg <= '0;
            index_reg <= '0;
            csum_reg  <= '0;
        end else begin
            case (state_reg)
                HDR: begin
                    if (accept) begin
                        count_reg <= in_data;
                        csum_reg  <= in_data;
                    end
                end
                DATA: begin
                    if (accept) begin
                        csum_reg <= csum_reg ^ in_data;
                        if (asm_last) begin
                            mem_addr_reg  <= ADDR_W'({index_reg, 2'b00});
                            mem_wdata_reg <= asm_word_next;
                        end
                    end
                end
                WRITE: begin
                    index_reg <= index_inc;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
// Directed byte streams against imem_loader. A stream-level model tracks how
// many bytes of the current load have been taken and which word write is
// owed, and a single negedge process compares every output to it each cycle.
// ---------------------------------------------------------------------------
module tb_imem_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic        cpu_hold;

    imem_loader #(
        .MAX_WORDS (128),
        .ADDR_W    (9)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .cpu_hold  (cpu_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- stream-level model ----------------
    bit          m_active = 0;   // a load is in flight
    int          m_res    = 0;   // 0 none, 1 good load, 2 failed load
    int          m_k      = 0;   // bytes taken in this load (header included)
    int          m_n      = 0;   // word count from the header
    int          m_words  = 0;   // words written so far
    bit          m_pend   = 0;   // a completed word is being written this cycle
    logic [7:0]  m_csum   = '0;
    logic [31:0] m_cur    = '0;
    logic [8:0]  m_addr   = '0;
    logic [31:0] m_data   = '0;

    // Observations for the directed tests
    int          cyc          = 0;
    int          wr_count     = 0;
    logic [8:0]  wr_last_addr = '0;
    logic [31:0] wr_last_data = '0;
    int          hdr_cyc      = 0;
    int          done_cyc     = 0;
    bit          done_seen    = 0;

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            m_active = 0; m_res = 0; m_k = 0; m_n = 0; m_words = 0;
            m_pend = 0; m_csum = '0; m_cur = '0; m_addr = '0; m_data = '0;
        end

        chk("in_ready",  in_ready,  m_active && !m_pend);
        chk("busy",      busy,      m_active);
        chk("done",      done,      !m_active && m_res == 1);
        chk("error",     error,     !m_active && m_res == 2);
        chk("cpu_hold",  cpu_hold,  !(!m_active && m_res == 1));
        chk("mem_we",    mem_we,    m_pend);
        chk("mem_addr",  mem_addr,  m_addr);
        chk("mem_wdata", mem_wdata, m_data);

        if (mem_we) begin
            wr_count++;
            wr_last_addr = mem_addr;
            wr_last_data = mem_wdata;
        end
        if (done && !done_seen) begin
            done_seen = 1;
            done_cyc  = cyc;
        end

        // Advance the model to what the coming rising edge must produce.
        if (reset) begin
            if (!m_active) begin
                if (start) begin
                    m_active = 1; m_res = 0; m_k = 0; m_words = 0;
                    m_csum = '0; done_seen = 0;
                end
            end else if (m_pend) begin
                m_pend = 0;
                m_words++;
            end else if (in_valid) begin
                if (m_k == 0) begin
                    m_n = int'(in_data);
                    m_csum = in_data;
                    m_k = 1;
                    hdr_cyc = cyc;
                    if (m_n == 0 || m_n > 128) begin
                        m_active = 0;
                        m_res = 2;
                    end
                end else if (m_words == m_n) begin
                    m_active = 0;
                    m_res = (in_data == m_csum) ? 1 : 2;
                end else begin
                    m_cur = {m_cur[23:0], in_data};
                    m_csum = m_csum ^ in_data;
                    m_k++;
                    if ((m_k - 1) % 4 == 0) begin
                        m_pend = 1;
                        m_addr = 9'(m_words * 4);
                        m_data = m_cur;
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [7:0] stream[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        logic got;
        int   t;
        in_valid = 1'b1;
        in_data  = b;
        got = 1'b0;
        t = 0;
        while (!got && t < 40) begin
            @(negedge clk);
            got = in_ready;
            tick();
            t++;
        end
        in_valid = 1'b0;
        chk("byte_accepted", got, 1);
    endtask

    task automatic send_stream(input bit gaps);
        foreach (stream[i]) begin
            send(stream[i]);
            if (gaps) tick();
        end
    endtask

    task automatic wait_settle();
        int t;
        t = 0;
        while (t < 2000) begin
            @(negedge clk);
            if (!busy) break;
            t++;
        end
        chk("settle", busy, 0);
        tick();
    endtask

    task automatic nominal_stream();
        stream = '{8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int base;

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        #1 reset = 1'b0;
        #1;
        chk("rst_in_ready",  in_ready,  0);
        chk("rst_busy",      busy,      0);
        chk("rst_done",      done,      0);
        chk("rst_error",     error,     0);
        chk("rst_cpu_hold",  cpu_hold,  1);
        chk("rst_mem_we",    mem_we,    0);
        chk("rst_mem_addr",  mem_addr,  0);
        chk("rst_mem_wdata", mem_wdata, 0);
        tick(); tick();
        reset = 1'b1;
        tick();

        // Nominal single-word load
        base = wr_count;
        pulse_start();
        nominal_stream();
        send_stream(0);
        wait_settle();
        chk("nom_writes",  wr_count - base, 1);
        chk("nom_addr",    wr_last_addr, 9'h000);
        chk("nom_data",    wr_last_data, 32'h12345678);
        chk("nom_done",    done, 1);
        chk("nom_hold",    cpu_hold, 0);
        chk("nom_latency", done_cyc - hdr_cyc, 7);

        // Zero count, then recovery
        base = wr_count;
        pulse_start();
        send(8'h00);
        wait_settle();
        chk("zero_error",  error, 1);
        chk("zero_writes", wr_count - base, 0);
        chk("zero_hold",   cpu_hold, 1);
        pulse_start();
        nominal_stream();
        send_stream(0);
        wait_settle();
        chk("retry_done",  done, 1);

        // Oversized count
        pulse_start();
        send(8'h81);
        wait_settle();
        chk("over_error",  error, 1);

        // Bad checksum, with a start pulse that must be ignored mid-load
        base = wr_count;
        pulse_start();
        send(8'h01);
        pulse_start();
        chk("mid_start_busy", busy, 1);
        stream = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h0A};
        send_stream(0);
        wait_settle();
        chk("bad_writes", wr_count - base, 1);
        chk("bad_error",  error, 1);
        chk("bad_hold",   cpu_hold, 1);

        // Two-word load
        base = wr_count;
        pulse_start();
        stream = '{8'h02, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44, 8'h46};
        send_stream(0);
        wait_settle();
        chk("two_writes", wr_count - base, 2);
        chk("two_addr",   wr_last_addr, 9'h004);
        chk("two_data",   wr_last_data, 32'h11223344);
        chk("two_done",   done, 1);

        // Gapped stream
        base = wr_count;
        pulse_start();
        nominal_stream();
        send_stream(1);
        wait_settle();
        chk("gap_writes", wr_count - base, 1);
        chk("gap_data",   wr_last_data, 32'h12345678);
        chk("gap_done",   done, 1);

        // Full fill: bytes 0..511 (mod 256) cancel in XOR, checksum is 0x80
        base = wr_count;
        stream.delete();
        stream.push_back(8'd128);
        for (int i = 0; i < 512; i++) stream.push_back(8'(i));
        stream.push_back(8'h80);
        pulse_start();
        send_stream(0);
        wait_settle();
        chk("full_writes", wr_count - base, 128);
        chk("full_addr",   wr_last_addr, 9'h1FC);
        chk("full_data",   wr_last_data, 32'hFCFDFEFF);
        chk("full_done",   done, 1);
        pulse_start();
        chk("reload_hold", cpu_hold, 1);
        chk("reload_busy", busy, 1);
        nominal_stream();
        send_stream(0);
        wait_settle();
        chk("reload_done", done, 1);
        chk("reload_hold_released", cpu_hold, 0);

        // Mid-load reset after the second data byte
        pulse_start();
        send(8'h01);
        send(8'h12);
        send(8'h34);
        reset = 1'b0;
        #1;
        chk("mrst_in_ready",  in_ready,  0);
        chk("mrst_busy",      busy,      0);
        chk("mrst_done",      done,      0);
        chk("mrst_error",     error,     0);
        chk("mrst_cpu_hold",  cpu_hold,  1);
        chk("mrst_mem_we",    mem_we,    0);
        chk("mrst_mem_addr",  mem_addr,  0);
        chk("mrst_mem_wdata", mem_wdata, 0);
        tick(); tick();
        reset = 1'b1;
        tick();
        base = wr_count;
        pulse_start();
        nominal_stream();
        send_stream(0);
        wait_settle();
        chk("post_rst_writes", wr_count - base, 1);
        chk("post_rst_data",   wr_last_data, 32'h12345678);
        chk("post_rst_done",   done, 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
